bram_rr_arbiter: RTL

//  Shares one synchronous port of an inferred block RAM between NREQ requesters.

---
 rtl/bram_rr_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: round-robin sharing of one synchronous block-RAM port among NREQ valid/ready requesters
module bram_rr_arbiter #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter int DEPTH = 1024,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ABITS-1:0]  req_addr,
  input  logic [NREQ*DBITS-1:0]  req_wdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ABITS-1:0]       mem_a,
  output logic [DBITS-1:0]       mem_wd,
  input  logic [DBITS-1:0]       mem_rd,
  output logic [NREQ-1:0]        rsp_valid,
  output logic                   rsp_we,
  output logic [DBITS-1:0]       rsp_rdata
);
  localparam int IW = $clog2(NREQ);
  if (DEPTH > (1 << ABITS) || NREQ < 2 || NREQ > 8) begin : g_bad_param
    $error("bram_rr_arbiter: DEPTH must be <= 2**ABITS and NREQ in 2..8");
  end
  logic [IW-1:0] last, gid, iss_id;
  logic en_q, we_q, hs;
  function automatic logic [IW-1:0] wrap(input int s);
    return IW'(s >= NREQ ? s - NREQ : s);
  endfunction
  always_comb begin
    gid = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[wrap(int'(last) + k)]) gid = wrap(int'(last) + k);
  end
  assign hs = rst_n && (|req_valid);
  assign req_ready = hs ? NREQ'(1) << gid : '0;
  assign mem_en = en_q & rst_n;
  assign mem_we = we_q & rst_n;
  assign rsp_rdata = mem_rd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= IW'(NREQ - 1);
      iss_id <= '0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      mem_a <= '0;
      mem_wd <= '0;
      rsp_valid <= '0;
      rsp_we <= 1'b0;
    end else begin
      en_q <= hs;
      we_q <= hs & req_we[gid];
      if (hs) begin
        last <= gid;
        iss_id <= gid;
        mem_a <= req_addr[gid*ABITS +: ABITS];
        mem_wd <= req_wdata[gid*DBITS +: DBITS];
      end
      rsp_valid <= en_q ? NREQ'(1) << iss_id : '0;
      rsp_we <= en_q & we_q;
    end
  end
  a_ready: assert property (@(posedge clk) $onehot0(req_ready) && (req_ready & ~req_valid) == '0);
  a_rsp: assert property (@(posedge clk) $onehot0(rsp_valid));
  a_we: assert property (@(posedge clk) mem_we |-> mem_en);
endmodule
